// File: rtl/reg_c_seq.sv
// reg_c_seq -- frame sequencer feeding a 15-bit remainder shift register.
//
// Accepts an N-bit word over a valid/ready handshake, clears the remainder
// register, drives its shift enable for exactly L = N+FLUSH cycles, then
// captures the remainder and offers it downstream over valid/ready.
//
// Optional feature macro: SEQ_CNT_CHECK_EN
//   defined   : in CAPTURE, reg_count is compared against L; a mismatch sets
//               err, which stays set until the next accepted word or reset.
//   undefined : err is tied low and reg_count is ignored.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous active-low reset
//   in_valid   in   1   upstream word valid
//   in_ready   out  1   high only in IDLE (and not in reset)
//   in_data    in   N   word to process
//   reg_clr    out  1   clear to the remainder register (also high in reset)
//   reg_shift  out  1   shift enable to the remainder register
//   reg_data   out  N   latched word, stable from accept to next accept
//   reg_count  in   11  register's shift count (checked only with the macro)
//   reg_out    in   RW  register's remainder
//   out_valid  out  1   result valid (HOLD)
//   out_ready  in   1   downstream accepts result
//   out_rem    out  RW  captured remainder
//   out_zero   out  1   captured remainder was zero
//   busy       out  1   frame in progress
//   err        out  1   shift-count check error
module reg_c_seq #(
  parameter int unsigned N     = 64,
  parameter int unsigned FLUSH = 0,
  parameter int unsigned RW    = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          reg_clr,
  output logic          reg_shift,
  output logic [N-1:0]  reg_data,
  input  logic [10:0]   reg_count,
  input  logic [RW-1:0] reg_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_rem,
  output logic          out_zero,
  output logic          busy,
  output logic          err
);

  localparam int unsigned L = N + FLUSH;
  localparam logic [10:0] L_CNT  = 11'(L);
  localparam logic [10:0] L_LAST = 11'(L - 1);

  if (L < 1 || L > 2047) begin : g_bad_len
    $error("reg_c_seq: N+FLUSH must lie in 1..2047");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_CAPTURE,
    S_HOLD
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [10:0] r_cnt;
  logic        w_accept;

  // Next state and handshake outputs. Outputs are gated with rst so the
  // register is cleared and nothing is offered during the reset cycle itself.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    reg_clr   = ~rst;
    reg_shift = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    w_accept  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = rst;
        w_accept = rst & in_valid;
        if (in_valid) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        reg_clr = 1'b1;
        busy    = rst;
        w_next  = S_SHIFT;
      end
      S_SHIFT: begin
        reg_shift = rst;
        busy      = rst;
        if (r_cnt == L_LAST) w_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        busy   = rst;
        w_next = S_HOLD;
      end
      S_HOLD: begin
        out_valid = rst;
        busy      = rst;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      reg_data <= '0;
      out_rem  <= '0;
      out_zero <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_CLEAR)      r_cnt <= '0;
      else if (r_state == S_SHIFT) r_cnt <= r_cnt + 11'd1;
      if (w_accept) reg_data <= in_data;
      if (r_state == S_CAPTURE) begin
        out_rem  <= reg_out;
        out_zero <= (reg_out == '0);
      end
    end
  end

`ifdef SEQ_CNT_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (w_accept) begin
      err <= 1'b0;
    end else if (r_state == S_CAPTURE && reg_count != L_CNT) begin
      err <= 1'b1;
    end
  end
`else
  logic w_unused_count;
  assign w_unused_count = ^{reg_count, L_CNT};
  always_comb err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_c_seq.sv
module tb_reg_c_seq;

  localparam int unsigned N  = 64;
  localparam int unsigned FL = 0;
  localparam int unsigned RW = 15;
  localparam int unsigned L  = N + FL;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          reg_clr;
  logic          reg_shift;
  logic [N-1:0]  reg_data;
  logic [10:0]   reg_count;
  logic [RW-1:0] reg_out;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_rem;
  logic          out_zero;
  logic          busy;
  logic          err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_c_seq #(.N(N), .FLUSH(FL), .RW(RW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .reg_clr(reg_clr), .reg_shift(reg_shift), .reg_data(reg_data),
    .reg_count(reg_count), .reg_out(reg_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rem(out_rem), .out_zero(out_zero),
    .busy(busy), .err(err)
  );

  // Remainder register model: MSB-first data bit XORed with the bit rotating
  // out of position 0, entering at the top.
  logic [RW-1:0] m_rem;
  int            m_cnt;
  logic          force_cnt;
  logic          m_bit;

  always_comb begin
    m_bit = 1'b0;
    if (m_cnt < int'(N)) m_bit = reg_data[N-1-m_cnt];
  end

  always @(posedge clk) begin
    if (reg_clr) begin
      m_rem <= '0;
      m_cnt <= 0;
    end else if (reg_shift) begin
      m_rem <= {m_bit ^ m_rem[0], m_rem[RW-1:1]};
      m_cnt <= m_cnt + 1;
    end
  end

  assign reg_out   = m_rem;
  assign reg_count = force_cnt ? 11'd63 : 11'(m_cnt);

  // Reference: word bit i is injected at position 14 and then rotated right
  // once per remaining shift, so it lands at (14 - i - FLUSH) mod 15.
  function automatic logic [RW-1:0] ref_rem(input logic [N-1:0] w);
    logic [RW-1:0] r;
    int p;
    r = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (w[i]) begin
        p = ((14 - (i + int'(FL))) % 15 + 15) % 15;
        r[p] = ~r[p];
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame starting from IDLE at a negedge. hold=0 means out_ready is
  // already high when HOLD is entered.
  task automatic run_frame(input logic [N-1:0] w, input int hold, input bit noise);
    int   edges;
    int   shifts;
    bit   seen;
    bit   dstable;
    logic [RW-1:0] exp_r;
    exp_r = ref_rem(w);
    chk("idle_in_ready", in_ready, 1);
    in_data   = w;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    chk("accept_clr_busy_rdy", {reg_clr, busy, in_ready}, 3'b110);
    chk("accept_reg_data", reg_data, w);
    chk("accept_err_clear", err, 0);
    in_valid = noise;
    if (noise) in_data = {$urandom, $urandom};
    edges = 0; shifts = 0; seen = 0; dstable = 1;
    while (!seen && edges < 200) begin
      @(negedge clk);
      edges++;
      if (reg_shift) shifts++;
      if (reg_data !== w) dstable = 0;
      if (out_valid) seen = 1;
    end
    in_valid = 1'b0;
    chk("out_valid_timeout", seen, 1);
    chk("latency_edges", edges, L + 2);
    chk("shift_cycles", shifts, L);
    chk("reg_data_stable", dstable, 1);
    chk("out_rem", out_rem, exp_r);
    chk("out_zero", out_zero, (exp_r == '0));
    chk("hold_in_ready", in_ready, 0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_stable", {out_valid, in_ready, out_rem}, {1'b1, 1'b0, exp_r});
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_1cyc", {out_valid, in_ready, busy}, 3'b010);
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0]  w;
    logic [RW-1:0] q[$];
    int            shifts;
    int            res_n;
    int            acc_n;
    int            last_acc;

    rst = 1'b0; in_valid = 1'b1; in_data = '1; out_ready = 1'b0; force_cnt = 1'b0;

    // Reset state, with in_valid asserted to show it is ignored.
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_clr_shift", {reg_clr, reg_shift}, 2'b10);
    chk("rst_valid_busy_err", {out_valid, busy, err}, 3'b000);
    chk("rst_out_rem_zero", {out_rem, out_zero}, '0);
    chk("rst_reg_data", reg_data, '0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {in_ready, reg_clr, busy}, 3'b100);

    // Directed frames.
    run_frame(64'h0, 0, 0);
    chk("zero_word_rem", {out_rem, out_zero}, {15'h0, 1'b1});
    run_frame(64'h1, 0, 0);
    chk("h1_rem", {out_rem, out_zero}, {15'h4000, 1'b0});
    run_frame(64'h2, 0, 0);
    chk("h2_rem", out_rem, 15'h2000);

    // Long hold with noise on the input side.
    run_frame({$urandom, $urandom}, 10, 1);

    // Randomised frames.
    for (int f = 0; f < 6; f++) begin
      run_frame({$urandom, $urandom}, int'($urandom_range(0, 3)), bit'(f[0]));
    end
    run_frame('1, 1, 0);

    // Reset during the 20th shift cycle.
    in_data = {$urandom, $urandom};
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    shifts = 0;
    for (int c = 0; c < 100 && shifts < 20; c++) begin
      @(negedge clk);
      if (reg_shift) shifts++;
    end
    chk("mid_reached_20", shifts, 20);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_outputs", {busy, reg_shift, reg_clr, out_valid, in_ready}, 5'b00100);
    chk("mid_rst_rem_discard", {out_rem, out_zero}, '0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_back_idle", {in_ready, busy}, 2'b10);
    run_frame({$urandom, $urandom}, 0, 0);

    // Back-to-back frames with in_valid and out_ready held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    res_n = 0; acc_n = 0; last_acc = -1;
    for (int cyc = 0; cyc < 400 && res_n < 4; cyc++) begin
      if (out_valid) begin
        if (q.size() > 0) chk("b2b_rem", out_rem, q.pop_front());
        else              chk("b2b_unexpected_result", 1, 0);
        res_n++;
      end
      if (in_ready) begin
        if (acc_n < 4) begin
          if (last_acc >= 0) chk("b2b_period", cyc - last_acc, L + 4);
          last_acc = cyc;
          w = {$urandom, $urandom};
          in_data = w;
          q.push_back(ref_rem(w));
          acc_n++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    chk("b2b_results", res_n, 4);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_idle", {in_ready, busy}, 2'b10);

    // Shift-count check using a wrong reg_count.
    force_cnt = 1'b1;
    run_frame({$urandom, $urandom}, 2, 0);
`ifdef SEQ_CNT_CHECK_EN
    chk("err_set_sticky", err, 1);
`else
    chk("err_tied_low", err, 0);
`endif
    force_cnt = 1'b0;
    run_frame({$urandom, $urandom}, 0, 0);
    chk("err_after_clean", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
